// File: rtl/modport_xor_responder_if.sv
// Request/response bundle between an initiator (master) and the XOR responder (slave).
interface modport_xor_responder_if #(
    parameter int WIDTH = 8
);
    logic             req_valid;
    logic             req_ready;
    logic             req_op;
    logic [WIDTH-1:0] req_in1;
    logic [WIDTH-1:0] req_in2;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic [15:0]      rsp_count;

    modport master (
        output req_valid, req_op, req_in1, req_in2, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_count
    );

    modport slave (
        input  req_valid, req_op, req_in1, req_in2, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_count
    );
endinterface

// File: rtl/modport_xor_responder.sv
// Pass/XOR responder: results are queued in a 2-entry FIFO whose occupancy
// is tracked by a three-state machine; rsp_count tallies completed handoffs.
module modport_xor_responder #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    modport_xor_responder_if.slave bus
);
    if (DEPTH != 2) begin : g_depth_check
        $error("modport_xor_responder supports DEPTH = 2 only");
    end

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [2];
    logic [WIDTH-1:0] mem_d [2];
    logic [15:0]      count_q, count_d;

    logic             req_ready;
    logic             rsp_valid;
    logic             accept;
    logic             handoff;
    logic [WIDTH-1:0] result;

    // Handshake outputs come only from registered state, never from rsp_ready.
    assign req_ready = (state_q != FULL);
    assign rsp_valid = (state_q != EMPTY);
    assign accept    = bus.req_valid && req_ready;
    assign handoff   = rsp_valid && bus.rsp_ready;
    assign result    = bus.req_op ? (bus.req_in1 ^ bus.req_in2) : bus.req_in1;

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_data  = rsp_valid ? mem_q[rd_ptr_q] : '0;
    assign bus.rsp_count = count_q;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        count_d  = count_q;

        if (accept) begin
            mem_d[wr_ptr_q] = result;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (handoff) begin
            rd_ptr_d = ~rd_ptr_q;
            count_d  = count_q + 16'd1;
        end

        case (state_q)
            EMPTY: if (accept) state_d = ONE;
            ONE: begin
                if (accept && !handoff)      state_d = FULL;
                else if (handoff && !accept) state_d = EMPTY;
            end
            FULL:    if (handoff) state_d = ONE;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= EMPTY;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            count_q  <= 16'd0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: tb/tb_modport_xor_responder.sv
// Bench for modport_xor_responder: directed scenarios plus random traffic
// checked against a queue-based model of the responder's behaviour.
module tb_modport_xor_responder;
    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;

    logic [7:0]  exp_q[$];
    logic [15:0] exp_cnt;

    always #5 clk = ~clk;

    modport_xor_responder_if #(.WIDTH(8)) bus ();

    modport_xor_responder #(.WIDTH(8), .DEPTH(2)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Advance one clock; the model consumes the inputs seen at the rising edge.
    task automatic tick();
        bit         acc, hs;
        logic [7:0] res;
        @(posedge clk);
        if (rst_n) begin
            acc = (bus.req_valid === 1'b1) && (exp_q.size() < 2);
            hs  = (exp_q.size() > 0) && (bus.rsp_ready === 1'b1);
            res = bus.req_op ? (bus.req_in1 ^ bus.req_in2) : bus.req_in1;
            if (hs) begin
                void'(exp_q.pop_front());
                exp_cnt = exp_cnt + 16'd1;
            end
            if (acc) exp_q.push_back(res);
        end else begin
            exp_q.delete();
            exp_cnt = 16'd0;
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.req_valid = 1'b0;
        bus.req_op    = 1'b0;
        bus.req_in1   = 8'h00;
        bus.req_in2   = 8'h00;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n   = 1'b0;
        exp_cnt = 16'd0;
        exp_q.delete();
        #3;
        n_vec++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready got %b want 1", bus.req_ready); end
        n_vec++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid); end
        n_vec++; if (bus.rsp_data !== 8'h00) begin n_err++; $display("FAIL reset_rsp_data got %h want 00", bus.rsp_data); end
        n_vec++; if (bus.rsp_count !== 16'h0000) begin n_err++; $display("FAIL reset_rsp_count got %h want 0000", bus.rsp_count); end
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    task automatic test_single_pass();
        bus.req_valid = 1'b1; bus.req_op = 1'b0; bus.req_in1 = 8'h42; bus.req_in2 = 8'h99;
        tick();
        bus.req_valid = 1'b0;
        n_vec++; if (bus.rsp_valid !== 1'b1) begin n_err++; $display("FAIL single_rsp_valid got %b want 1", bus.rsp_valid); end
        n_vec++; if (bus.rsp_data !== 8'h42) begin n_err++; $display("FAIL single_rsp_data got %h want 42", bus.rsp_data); end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        n_vec++; if (bus.rsp_count !== 16'd1) begin n_err++; $display("FAIL single_rsp_count got %0d want 1", bus.rsp_count); end
        n_vec++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL single_empty got rsp_valid %b want 0", bus.rsp_valid); end
    endtask

    task automatic test_xor();
        logic [7:0] a [2];
        logic [7:0] b [2];
        logic [7:0] want [2];
        a[0] = 8'hF0; b[0] = 8'h0F; want[0] = 8'hFF;
        a[1] = 8'hAB; b[1] = 8'hAB; want[1] = 8'h00;
        for (int i = 0; i < 2; i++) begin
            bus.req_valid = 1'b1; bus.req_op = 1'b1; bus.req_in1 = a[i]; bus.req_in2 = b[i];
            bus.rsp_ready = 1'b0;
            tick();
            bus.req_valid = 1'b0;
            n_vec++; if (bus.rsp_data !== want[i] || bus.rsp_valid !== 1'b1) begin
                n_err++; $display("FAIL xor_%0d got %h valid %b want %h", i, bus.rsp_data, bus.rsp_valid, want[i]);
            end
            bus.rsp_ready = 1'b1;
            tick();
            bus.rsp_ready = 1'b0;
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] want [3];
        int         k = 0;
        int         guard = 0;
        bit         drop;
        want[0] = 8'h11; want[1] = 8'h22; want[2] = 8'h33;
        bus.rsp_ready = 1'b0; bus.req_op = 1'b0; bus.req_valid = 1'b1;
        bus.req_in1 = 8'h11; tick();
        bus.req_in1 = 8'h22; tick();
        bus.req_in1 = 8'h33;
        for (int i = 0; i < 2; i++) begin
            n_vec++; if (bus.req_ready !== 1'b0) begin n_err++; $display("FAIL bp_req_ready cycle %0d got %b want 0", i, bus.req_ready); end
            n_vec++; if (bus.rsp_data !== 8'h11) begin n_err++; $display("FAIL bp_stable cycle %0d got %h want 11", i, bus.rsp_data); end
            tick();
        end
        bus.rsp_ready = 1'b1;
        while (k < 3 && guard < 10) begin
            drop = bus.req_valid && bus.req_ready;
            if (bus.rsp_valid) begin
                n_vec++; if (bus.rsp_data !== want[k]) begin n_err++; $display("FAIL bp_order_%0d got %h want %h", k, bus.rsp_data, want[k]); end
                k++;
            end
            tick();
            if (drop) bus.req_valid = 1'b0;
            guard++;
        end
        n_vec++; if (k != 3) begin n_err++; $display("FAIL bp_drain got %0d responses want 3", k); end
        bus.req_valid = 1'b0; bus.rsp_ready = 1'b0;
        tick();
    endtask

    task automatic test_streaming();
        logic [15:0] start_cnt;
        bus.req_valid = 1'b1; bus.req_op = 1'b0; bus.req_in1 = 8'($urandom); bus.rsp_ready = 1'b0;
        tick();
        start_cnt = exp_cnt;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.req_op = 1'($urandom); bus.req_in1 = 8'($urandom); bus.req_in2 = 8'($urandom);
            tick();
            n_vec++; if (bus.rsp_valid !== 1'b1 || bus.req_ready !== 1'b1) begin
                n_err++; $display("FAIL stream_state cycle %0d got valid %b ready %b want 1 1", i, bus.rsp_valid, bus.req_ready);
            end
            n_vec++; if (bus.rsp_data !== exp_q[0]) begin n_err++; $display("FAIL stream_data cycle %0d got %h want %h", i, bus.rsp_data, exp_q[0]); end
            n_vec++; if (bus.rsp_count !== start_cnt + 16'(i + 1)) begin
                n_err++; $display("FAIL stream_count cycle %0d got %0d want %0d", i, bus.rsp_count, start_cnt + 16'(i + 1));
            end
        end
        bus.req_valid = 1'b0;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            bus.req_valid = ($urandom_range(0, 9) < 7);
            bus.rsp_ready = ($urandom_range(0, 9) < 6);
            bus.req_op    = 1'($urandom);
            bus.req_in1   = bus.req_valid ? 8'($urandom) : 8'bx;
            bus.req_in2   = bus.req_valid ? 8'($urandom) : 8'bx;
            tick();
            n_vec++; if (bus.req_ready !== (exp_q.size() < 2)) begin n_err++; $display("FAIL rand_req_ready cycle %0d got %b", i, bus.req_ready); end
            n_vec++; if (bus.rsp_valid !== (exp_q.size() > 0)) begin n_err++; $display("FAIL rand_rsp_valid cycle %0d got %b", i, bus.rsp_valid); end
            if (exp_q.size() > 0) begin
                n_vec++; if (bus.rsp_data !== exp_q[0]) begin n_err++; $display("FAIL rand_rsp_data cycle %0d got %h want %h", i, bus.rsp_data, exp_q[0]); end
            end
            n_vec++; if (bus.rsp_count !== exp_cnt) begin n_err++; $display("FAIL rand_rsp_count cycle %0d got %0d want %0d", i, bus.rsp_count, exp_cnt); end
        end
        idle_inputs();
        bus.rsp_ready = 1'b1;
        repeat (3) tick();
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        bus.rsp_ready = 1'b0; bus.req_valid = 1'b1; bus.req_op = 1'b0;
        bus.req_in1 = 8'hCD; tick();
        bus.req_in1 = 8'hEF; tick();
        bus.req_valid = 1'b0;
        n_vec++; if (bus.req_ready !== 1'b0) begin n_err++; $display("FAIL mid_full got req_ready %b want 0", bus.req_ready); end
        bus.rsp_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        n_vec++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL mid_rsp_valid got %b want 0", bus.rsp_valid); end
        n_vec++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL mid_req_ready got %b want 1", bus.req_ready); end
        n_vec++; if (bus.rsp_count !== 16'h0000) begin n_err++; $display("FAIL mid_rsp_count got %h want 0000", bus.rsp_count); end
        @(negedge clk);
        tick();
        rst_n = 1'b1;
        tick();
        n_vec++; if (bus.rsp_valid !== 1'b0 || bus.rsp_data !== 8'h00 || bus.rsp_count !== 16'h0000) begin
            n_err++; $display("FAIL mid_stale got valid %b data %h count %h want 0 00 0000", bus.rsp_valid, bus.rsp_data, bus.rsp_count);
        end
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_counter_wrap();
        int guard = 0;
        bus.req_valid = 1'b1; bus.req_op = 1'b0; bus.req_in1 = 8'h5A; bus.rsp_ready = 1'b0;
        tick();
        bus.rsp_ready = 1'b1;
        while (exp_cnt != 16'hFFFF && guard < 70000) begin
            bus.req_in1 = 8'(guard);
            tick();
            guard++;
        end
        n_vec++; if (bus.rsp_count !== 16'hFFFF) begin n_err++; $display("FAIL wrap_ffff got %h want ffff", bus.rsp_count); end
        tick();
        n_vec++; if (bus.rsp_count !== 16'h0000) begin n_err++; $display("FAIL wrap_zero got %h want 0000", bus.rsp_count); end
        tick();
        n_vec++; if (bus.rsp_count !== 16'h0001) begin n_err++; $display("FAIL wrap_one got %h want 0001", bus.rsp_count); end
        n_vec++; if (bus.rsp_data !== exp_q[0]) begin n_err++; $display("FAIL wrap_data got %h want %h", bus.rsp_data, exp_q[0]); end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single_pass();
        test_xor();
        test_backpressure();
        test_streaming();
        test_random();
        test_reset_mid();
        test_counter_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/modport_xor_responder.md
MODPORT_XOR_RESPONDER -- requirements
Module: modport_xor_responder

Interface
REQ-001 Parameter WIDTH, default 8: data width of request operands and response data.
REQ-002 Parameter DEPTH, fixed at 2: number of response buffer entries; values other than 2 are not supported.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 req_valid  input  1  initiator presents a request this cycle.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_op  input  1  operation select: 0 = pass in1, 1 = in1 ^ in2.
REQ-008 req_in1  input  WIDTH  first operand.
REQ-009 req_in2  input  WIDTH  second operand.
REQ-010 rsp_valid  output  1  response data valid.
REQ-011 rsp_ready  input  1  initiator consumes the response this cycle.
REQ-012 rsp_data  output  WIDTH  response value at buffer head.
REQ-013 rsp_count  output  16  running count of completed responses.

Function
REQ-014 Request accept: req_valid && req_ready at a rising clk edge.
REQ-015 Response handoff: rsp_valid && rsp_ready at a rising clk edge.
REQ-016 On request accept, the result SHALL be computed combinationally from req_op, req_in1 and req_in2 and written to the tail of a 2-entry FIFO.
- Result is req_in1 when req_op = 0.
- Result is req_in1 ^ req_in2 when req_op = 1.
- Result is exactly WIDTH bits; there is no extension or truncation.
REQ-017 Occupancy state machine SHALL have states EMPTY, ONE and FULL.
- EMPTY to ONE on accept.
- ONE to FULL on accept without handoff.
- ONE to EMPTY on handoff without accept.
- FULL to ONE on handoff.
- All other combinations hold the current state.
REQ-018 req_ready SHALL be 1 in EMPTY and ONE and 0 in FULL; it SHALL be registered-state-derived only, with no combinational path from rsp_ready.
REQ-019 rsp_valid SHALL be 1 in ONE and FULL and 0 in EMPTY.
REQ-020 rsp_data SHALL show the oldest unconsumed result and SHALL stay stable while rsp_valid && !rsp_ready.
REQ-021 Minimum latency: a request accepted at edge N SHALL produce rsp_valid = 1 with its result after edge N; there is no same-cycle bypass.
REQ-022 Simultaneous accept and handoff in ONE SHALL:
- stay in ONE;
- pop the old entry;
- push the new result, which becomes the head after the edge.
REQ-023 In FULL, req_valid SHALL be ignored (no accept); a handoff in the same cycle frees one entry for the next cycle.
REQ-024 FIFO read and write pointers are 1 bit each and SHALL wrap from 1 to 0.
REQ-025 rsp_count SHALL increment by 1 on each handoff and SHALL wrap from 16'hFFFF to 16'h0000.
REQ-026 Ordering SHALL be strictly FIFO; no request is dropped or duplicated.
REQ-027 X on req_in1/req_in2 while req_valid = 0 SHALL NOT affect state.

Reset
REQ-028 While rst_n = 0, independent of clk, the block SHALL hold:
- state EMPTY;
- both pointers 0;
- req_ready = 1;
- rsp_valid = 0;
- rsp_data = 0;
- rsp_count = 0;
- FIFO entries = 0.
REQ-029 Reset asserted mid-operation SHALL discard all buffered results immediately, with no handoff completing.
REQ-030 The first accept SHALL be possible at the first rising edge after rst_n deasserts.

Verification
REQ-031 Single pass: reset, then req_op=0, in1=8'h42, one accept -> next cycle rsp_valid=1, rsp_data=8'h42; rsp_ready=1 -> rsp_count=1, back to EMPTY.
REQ-032 XOR: in1=8'hF0, in2=8'h0F, op=1 -> rsp_data=8'hFF; then in1=8'hAB, in2=8'hAB -> 8'h00.
REQ-033 Backpressure: rsp_ready=0, three requests 8'h11, 8'h22, 8'h33 (op=0) -> first two accepted, req_ready=0 while 8'h33 holds, rsp_data stable at 8'h11; release rsp_ready -> outputs 8'h11, 8'h22, 8'h33 in order.
REQ-034 Streaming: req_valid=1 and rsp_ready=1 every cycle for 10 cycles after the first fill -> one result per cycle, state stays ONE, rsp_count advances by 1 per cycle.
REQ-035 Reset mid-operation: FULL with 8'hCD, 8'hEF, rst_n pulsed low between edges -> immediately rsp_valid=0, req_ready=1, rsp_count=0; no stale data after release.
REQ-036 Counter wrap: force 65536 handoffs -> rsp_count reads 16'h0000, then 16'h0001 after the next handoff.
